// File: rtl/seq_mult_radix4.sv
// Radix-4 sequential multiplier: one 2-bit multiplier digit per cycle,
// unsigned or two's-complement signed, with a start/busy/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request, sampled only while idle
//   signed_mode 1 = operands are two's complement
//   a, b        WIDTH-bit multiplicand / multiplier
//   busy        operation in flight
//   done        one-cycle pulse when p updates
//   p           2*WIDTH-bit product, held between operations
module seq_mult_radix4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int ITER = WIDTH / 2;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic               r_neg;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic [WIDTH+1:0]   w_pp;
  logic [AW-1:0]      w_acc_nxt;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_fix;

  // -2^(W-1) negates to itself, which read unsigned is its magnitude.
  assign w_abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  always_comb begin
    w_pp = '0;
    unique case (r_mb[1:0])
      2'd0: w_pp = '0;
      2'd1: w_pp = {2'b00, r_ma};
      2'd2: w_pp = {1'b0, r_ma, 1'b0};
      2'd3: w_pp = {2'b00, r_ma} + {1'b0, r_ma, 1'b0};
      default: w_pp = '0;
    endcase
  end

  // Digit k lands at bit W-2 and is shifted right ITER-1-k more
  // times, leaving it at weight 4^k once all digits are in.
  assign w_acc_nxt = (r_acc >> 2) + (AW'(w_pp) << (WIDTH - 2));

  assign w_mag = r_acc[2*WIDTH-1:0];
  assign w_fix = r_neg ? -w_mag : w_mag;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_neg  <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_p    <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ma  <= w_abs_a;
            r_mb  <= w_abs_b;
            r_neg <= w_neg;
            r_acc <= '0;
            r_cnt <= CW'(ITER);
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_mb  <= r_mb >> 2;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_p <= w_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_seq_mult_radix4.sv
// Directed and swept checks of seq_mult_radix4 at WIDTH 4, 8 and 16.
// Expected products come from hand values and a longint reference.
module tb_seq_mult_radix4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        st8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        st16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_mult_radix4 #(.WIDTH(4)) u_m4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );
  seq_mult_radix4 #(.WIDTH(8)) u_m8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );
  seq_mult_radix4 #(.WIDTH(16)) u_m16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input int w, input bit sm,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    longint sa, sb, pr, mask;
    sa = longint'(a) & ((64'sd1 << w) - 1);
    sb = longint'(b) & ((64'sd1 << w) - 1);
    if (sm) begin
      if (sa[w-1]) sa = sa - (64'sd1 << w);
      if (sb[w-1]) sb = sb - (64'sd1 << w);
    end
    pr   = sa * sb;
    mask = (64'sd1 << (2 * w)) - 1;
    return 32'(pr & mask);
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic [31:0] get_p(input int w);
    case (w)
      4:       return 32'(p4);
      8:       return 32'(p8);
      default: return p16;
    endcase
  endfunction

  // Called #1 after an edge; returns edges from accept to done.
  task automatic mul(input int w, input bit sm,
                     input logic [15:0] a, input logic [15:0] b,
                     output logic [31:0] p, output int lat);
    case (w)
      4: begin a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; st4 = 1'b1; end
      8: begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; st8 = 1'b1; end
      default: begin a16 = a; b16 = b; sm16 = sm; st16 = 1'b1; end
    endcase
    @(posedge clk); #1;
    st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    lat = 0;
    while (!get_done(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!get_done(w)) chk("timeout", 32'(lat), 32'(w / 2 + 1));
    p = get_p(w);
  endtask

  logic [31:0] pr;
  int          lat;
  int          ndone;
  int          t0;

  initial begin
    st4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    st8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    st16 = 0; sm16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_p", 32'(p8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 255*255 with cycle-by-cycle handshake checks
    a8 = 8'd255; b8 = 8'd255; sm8 = 0; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    chk("u255_busy0", 32'(busy8), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("u255_busy", 32'(busy8), 32'd1);
      chk("u255_nodone", 32'(done8), 32'd0);
    end
    @(posedge clk); #1;
    chk("u255_done", 32'(done8), 32'd1);
    chk("u255_idle", 32'(busy8), 32'd0);
    chk("u255_p", 32'(p8), 32'hFE01);
    @(posedge clk); #1;
    chk("u255_done_off", 32'(done8), 32'd0);
    chk("u255_hold", 32'(p8), 32'hFE01);

    mul(8, 1, 16'h00FD, 16'h0005, pr, lat);
    chk("s_m3x5", pr, 32'h0000FFF1);
    chk("s_m3x5_lat", 32'(lat), 32'd5);
    mul(8, 1, 16'h0080, 16'h0080, pr, lat);
    chk("s_m128sq", pr, 32'h00004000);
    mul(8, 1, 16'h0080, 16'h007F, pr, lat);
    chk("s_m128x127", pr, 32'h0000C080);

    // start while busy must be ignored
    a8 = 8'h12; b8 = 8'h34; sm8 = 0; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    chk("ign_busy2", 32'(busy8), 32'd1);
    ndone = 0;
    t0 = 0;
    for (int e = 3; e <= 12; e++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        t0 = e;
        chk("ign_p", 32'(p8), 32'h03A8);
      end
      if (e < 5) chk("ign_busy", 32'(busy8), 32'd1);
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_edge", 32'(t0), 32'd5);

    // back-to-back with start held high
    a8 = 8'd7; b8 = 8'd9; sm8 = 0; st8 = 1;
    @(posedge clk); #1;
    t0 = -1;
    ndone = 0;
    for (int e = 1; e <= 20 && ndone < 2; e++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          chk("b2b_p1", 32'(p8), 32'd63);
          chk("b2b_e1", 32'(e), 32'd5);
          t0 = e;
          a8 = 8'd10; b8 = 8'd10;
        end else begin
          chk("b2b_p2", 32'(p8), 32'd100);
          chk("b2b_gap", 32'(e - t0), 32'd6);
        end
      end
      if (e == t0 + 1) st8 = 0;
    end
    st8 = 0;
    chk("b2b_ndone", 32'(ndone), 32'd2);

    // reset mid-operation
    a8 = 8'd200; b8 = 8'd200; sm8 = 0; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_p", 32'(p8), 32'd0);
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    mul(8, 0, 16'd2, 16'd3, pr, lat);
    chk("mrst_next", pr, 32'd6);
    chk("mrst_lat", 32'(lat), 32'd5);

    // WIDTH=4 instance
    mul(4, 0, 16'hF, 16'hF, pr, lat);
    chk("w4_u15sq", pr, 32'hE1);
    chk("w4_lat", 32'(lat), 32'd3);
    mul(4, 1, 16'h8, 16'h8, pr, lat);
    chk("w4_m8sq", pr, 32'h40);
    mul(4, 1, 16'h8, 16'h7, pr, lat);
    chk("w4_m8x7", pr, 32'hC8);

    // WIDTH=16 corner
    mul(16, 1, 16'h8000, 16'h8000, pr, lat);
    chk("w16_minsq", pr, 32'h40000000);
    chk("w16_lat", 32'(lat), 32'd9);

    // sweep against the reference
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 4 : (wi == 1) ? 8 : 16;
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra, rb;
        bit          rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (i < 4) begin
          ra = (i[0]) ? 16'h0000 : 16'hFFFF;
          rb = (i[1]) ? 16'h0000 : 16'hFFFF;
        end
        mul(w, rs, ra, rb, pr, lat);
        chk($sformatf("sweep_w%0d", w), pr, ref_mul(w, rs, ra, rb));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
